sgd_model_update: RTL and testbench

SGD_MODEL_UPDATE -- requirements
Module: sgd_model_update

---
 rtl/sgd_pkg.sv | 47 ++++
 rtl/sgd_model_update_ram.sv | 24 ++
 rtl/sgd_model_update.sv | 215 +++++++++++++++++++++
 tb/tb_sgd_model_update.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_pkg.sv
// Shared parameters, types and lane arithmetic for the SGD model-update block.
// SGD_UPDATE_SATURATE_EN selects saturating lane arithmetic; otherwise results wrap modulo 2^32.
package sgd_pkg;

    localparam int NUM_BITS_PER_BANK = 4;
    localparam int BIT_WIDTH_OF_BANK = 2;
    localparam int ENGINE_NUM_WIDTH  = 1;
    localparam int CHUNK_SHIFT       = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH;
    localparam int LANE_W            = 32;
    localparam int ADDR_W            = 12;
    localparam int VEC_W             = NUM_BITS_PER_BANK * LANE_W;

    typedef logic [NUM_BITS_PER_BANK-1:0][LANE_W-1:0] lane_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ACCUM,
        ST_UPDATE,
        ST_DONE
    } sgd_state_t;

    function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
        logic [LANE_W:0]   s;
        logic [LANE_W-1:0] r;
        s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
        r = s[LANE_W-1:0];
`ifdef SGD_UPDATE_SATURATE_EN
        if (s[LANE_W] != s[LANE_W-1]) r = s[LANE_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return r;
    endfunction

    function automatic logic [LANE_W-1:0] lane_sub(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
        logic [LANE_W:0]   s;
        logic [LANE_W-1:0] r;
        s = {a[LANE_W-1], a} - {b[LANE_W-1], b};
        r = s[LANE_W-1:0];
`ifdef SGD_UPDATE_SATURATE_EN
        if (s[LANE_W] != s[LANE_W-1]) r = s[LANE_W] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return r;
    endfunction

endpackage

// File: rtl/sgd_model_update_ram.sv
// Simple dual-port vector RAM (one write, one read) with registered read.
// A read of the address being written in the same cycle returns the old word.
module sgd_vec_ram
    import sgd_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = VEC_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sgd_model_update.sv
// Mini-batch SGD model update: accumulates chunked gradients, then applies x -= grad >>> step_shift.
// SGD_UPDATE_SATURATE_EN (in sgd_pkg) makes accumulate/update saturate instead of wrap.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a rising edge on started
// ST_INIT   | zeroing model words 0..chunk_count-1
// ST_ACCUM  | accepting gradient chunks into the batch buffer
// ST_UPDATE | walking the model, applying the batch gradient (chunk_count+2 cycles)
// ST_DONE   | run finished, done held until the next started edge
module sgd_model_update
    import sgd_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          started,
    input  logic [31:0]                   number_of_epochs,
    input  logic [31:0]                   number_of_samples,
    input  logic [31:0]                   dimension,
    input  logic [15:0]                   mini_batch_size,
    input  logic [4:0]                    step_shift,
    input  lane_vec_t                     acc_gradient,
    input  logic [NUM_BITS_PER_BANK-1:0]  acc_gradient_valid,
    input  logic [ADDR_W-1:0]             x_rd_addr,
    output logic [VEC_W-1:0]              x_rd_data,
    output logic                          busy,
    output logic                          x_updated,
    output logic                          epoch_done,
    output logic                          done,
    output logic                          err_overrun
);

    sgd_state_t        state, state_nx;
    logic              started_q;
    logic [ADDR_W-1:0] chunk_count, ptr;
    logic [ADDR_W:0]   upd_addr, upd_left;
    logic [31:0]       sample_cnt, epoch_cnt;
    logic [15:0]       batch_cnt, batch_target;
    logic              start_pulse, grad_valid, accept, chunk_last, batch_end;
    logic              upd_rd, upd_last, epoch_end, run_end;
    logic              unused_valid_lanes;

    assign start_pulse  = started & ~started_q;
    assign grad_valid   = acc_gradient_valid[0];
    assign unused_valid_lanes = ^acc_gradient_valid[NUM_BITS_PER_BANK-1:1];
    assign accept       = (state == ST_ACCUM) && grad_valid;
    assign batch_target = (mini_batch_size == 16'd0) ? 16'd1 : mini_batch_size;
    assign chunk_last   = ({1'b0, ptr} + 13'd1) >= {1'b0, chunk_count};
    assign batch_end    = (batch_cnt + 16'd1 == batch_target) ||
                          (sample_cnt + 32'd1 == number_of_samples);
    assign upd_rd       = upd_addr < {1'b0, chunk_count};
    assign upd_last     = (upd_left == '0);
    assign epoch_end    = (sample_cnt == number_of_samples);
    assign run_end      = epoch_end && (epoch_cnt + 32'd1 == number_of_epochs);
    assign busy         = (state == ST_INIT) || (state == ST_UPDATE);
    assign done         = (state == ST_DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start_pulse) state_nx = ST_INIT;
            ST_INIT: begin
                if (chunk_last)
                    state_nx = (number_of_samples == 32'd0 || number_of_epochs == 32'd0)
                               ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM:  if (accept && chunk_last && batch_end) state_nx = ST_UPDATE;
            ST_UPDATE: if (upd_last) state_nx = run_end ? ST_DONE : ST_ACCUM;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            started_q   <= 1'b0;
            chunk_count <= '0;
            ptr         <= '0;
            upd_addr    <= '0;
            upd_left    <= '0;
            sample_cnt  <= '0;
            batch_cnt   <= '0;
            epoch_cnt   <= '0;
            x_updated   <= 1'b0;
            epoch_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state      <= state_nx;
            started_q  <= started;
            x_updated  <= 1'b0;
            epoch_done <= 1'b0;
            if (grad_valid && busy) err_overrun <= 1'b1;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_pulse) begin
                        chunk_count <= ADDR_W'((dimension >> CHUNK_SHIFT) +
                                               32'(|dimension[CHUNK_SHIFT-1:0]));
                        ptr        <= '0;
                        sample_cnt <= '0;
                        batch_cnt  <= '0;
                        epoch_cnt  <= '0;
                    end
                end
                ST_INIT: ptr <= chunk_last ? '0 : ptr + 12'd1;
                ST_ACCUM: begin
                    if (accept) begin
                        if (chunk_last) begin
                            ptr        <= '0;
                            sample_cnt <= sample_cnt + 32'd1;
                            batch_cnt  <= batch_cnt + 16'd1;
                        end else begin
                            ptr <= ptr + 12'd1;
                        end
                        if (chunk_last && batch_end) begin
                            upd_addr <= '0;
                            upd_left <= {1'b0, chunk_count} + 13'd1;
                        end
                    end
                end
                ST_UPDATE: begin
                    upd_addr <= upd_addr + 13'd1;
                    upd_left <= upd_left - 13'd1;
                    if (upd_last) begin
                        x_updated <= 1'b1;
                        batch_cnt <= '0;
                        if (epoch_end) begin
                            epoch_done <= 1'b1;
                            sample_cnt <= '0;
                            epoch_cnt  <= epoch_cnt + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    lane_vec_t         grad_rd, grad_fwd, acc_sum, model_rd, x_new;
    lane_vec_t         p1_data, wq_data, w_data, model_wd;
    logic              p1_valid, p1_first, wq_valid, u1_valid, w_valid, model_we;
    logic [ADDR_W-1:0] p1_addr, wq_addr, u1_addr, w_addr, model_wa;
    logic [ADDR_W-1:0] grad_rd_addr, grad_rd_addr_q, model_rd_addr;

    assign grad_rd_addr  = (state == ST_UPDATE) ? upd_addr[ADDR_W-1:0] : ptr;
    assign model_rd_addr = (state == ST_UPDATE) ? upd_addr[ADDR_W-1:0] : x_rd_addr;
    assign x_rd_data     = model_rd;
    // The buffer read issued last cycle missed the write that landed on the same edge.
    assign grad_fwd      = (wq_valid && wq_addr == grad_rd_addr_q) ? wq_data : grad_rd;

    always_comb begin
        acc_sum = '0;
        x_new   = '0;
        for (int i = 0; i < NUM_BITS_PER_BANK; i++) begin
            acc_sum[i] = p1_first ? p1_data[i] : lane_add(grad_fwd[i], p1_data[i]);
            x_new[i]   = lane_sub(model_rd[i], $signed(grad_fwd[i]) >>> step_shift);
        end
    end

    always_comb begin
        model_we = w_valid;
        model_wa = w_addr;
        model_wd = w_data;
        if (state == ST_INIT) begin
            model_we = 1'b1;
            model_wa = ptr;
            model_wd = '0;
        end
        model_we = model_we & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            wq_valid <= 1'b0;
            u1_valid <= 1'b0;
            w_valid  <= 1'b0;
        end else begin
            p1_valid <= accept;
            wq_valid <= p1_valid;
            u1_valid <= (state == ST_UPDATE) && upd_rd;
            w_valid  <= u1_valid;
        end
    end

    always_ff @(posedge clk) begin
        p1_addr        <= ptr;
        p1_data        <= acc_gradient;
        p1_first       <= (batch_cnt == 16'd0);
        wq_addr        <= p1_addr;
        wq_data        <= acc_sum;
        u1_addr        <= upd_addr[ADDR_W-1:0];
        w_addr         <= u1_addr;
        w_data         <= x_new;
        grad_rd_addr_q <= grad_rd_addr;
    end

    sgd_vec_ram u_grad_ram (
        .clk     (clk),
        .wr_en   (p1_valid & rst_n),
        .wr_addr (p1_addr),
        .wr_data (acc_sum),
        .rd_addr (grad_rd_addr),
        .rd_data (grad_rd)
    );

    sgd_vec_ram u_model_ram (
        .clk     (clk),
        .wr_en   (model_we),
        .wr_addr (model_wa),
        .wr_data (model_wd),
        .rd_addr (model_rd_addr),
        .rd_data (model_rd)
    );

endmodule

// File: tb/tb_sgd_model_update.sv
// Directed self-checking bench for sgd_model_update.
module tb_sgd_model_update;
    import sgd_pkg::*;

    localparam int CW = 1 << (BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH);

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         started = 1'b0;
    logic [31:0]                  number_of_epochs = 0, number_of_samples = 0, dimension = 0;
    logic [15:0]                  mini_batch_size = 0;
    logic [4:0]                   step_shift = 0;
    lane_vec_t                    acc_gradient = '0;
    logic [NUM_BITS_PER_BANK-1:0] acc_gradient_valid = '0;
    logic [ADDR_W-1:0]            x_rd_addr = '0;
    logic [VEC_W-1:0]             x_rd_data;
    logic                         busy, x_updated, epoch_done, done, err_overrun;
    int                           total = 0;
    int                           bad = 0;

    always #5 clk = ~clk;

    sgd_model_update dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .started            (started),
        .number_of_epochs   (number_of_epochs),
        .number_of_samples  (number_of_samples),
        .dimension          (dimension),
        .mini_batch_size    (mini_batch_size),
        .step_shift         (step_shift),
        .acc_gradient       (acc_gradient),
        .acc_gradient_valid (acc_gradient_valid),
        .x_rd_addr          (x_rd_addr),
        .x_rd_data          (x_rd_data),
        .busy               (busy),
        .x_updated          (x_updated),
        .epoch_done         (epoch_done),
        .done               (done),
        .err_overrun        (err_overrun)
    );

    task automatic drive_grad(input logic [31:0] v, input logic vld);
        for (int i = 0; i < NUM_BITS_PER_BANK; i++) acc_gradient[i] = v;
        acc_gradient_valid = {NUM_BITS_PER_BANK{vld}};
    endtask

    task automatic send_chunk(input logic [31:0] v);
        drive_grad(v, 1'b1);
        @(negedge clk);
        drive_grad(32'd0, 1'b0);
    endtask

    task automatic start_run(input int ep, input int sm, input int chunks, input int mb,
                             input int sh, output logic ready);
        number_of_epochs  = ep;
        number_of_samples = sm;
        dimension         = chunks * CW;
        mini_batch_size   = 16'(mb);
        step_shift        = 5'(sh);
        started = 1'b1;
        @(negedge clk);
        started = 1'b0;
        for (int i = 0; i < 64 && busy; i++) @(negedge clk);
        ready = !busy;
    endtask

    task automatic wait_xupd(output int nbusy, output logic ep, output logic seen);
        nbusy = 0;
        ep    = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (x_updated) begin
                seen = 1'b1;
                ep   = epoch_done;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic read_x(input int addr, output logic [VEC_W-1:0] d);
        x_rd_addr = ADDR_W'(addr);
        @(negedge clk);
        d = x_rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, x_updated, epoch_done, err_overrun} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b required=00000",
                     {busy, done, x_updated, epoch_done, err_overrun});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, x_updated, epoch_done, err_overrun} !== 5'b0) begin
            bad++;
            $display("FAIL idle_outputs got=%b required=00000",
                     {busy, done, x_updated, epoch_done, err_overrun});
        end
    endtask

    task automatic test_single_update();
        logic rdy, ep, seen;
        int nb;
        logic [VEC_W-1:0] d;
        start_run(1, 1, 2, 1, 0, rdy);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL s1_init_timeout got=%b required=1", rdy); end
        send_chunk(32'd4);
        send_chunk(32'd4);
        wait_xupd(nb, ep, seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL s1_xupd_timeout got=%b required=1", seen); end
        total++;
        if (nb != 4) begin bad++; $display("FAIL s1_update_cycles got=%0d required=4", nb); end
        total++;
        if ({ep, done} !== 2'b11) begin bad++; $display("FAIL s1_epoch_done got=%b required=11", {ep, done}); end
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFFC}}) begin bad++; $display("FAIL s1_x0 got=%h required=all fffffffc", d); end
        read_x(1, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFFC}}) begin bad++; $display("FAIL s1_x1 got=%h required=all fffffffc", d); end
        total++;
        if (err_overrun !== 1'b0) begin bad++; $display("FAIL s1_no_overrun got=%b required=0", err_overrun); end
    endtask

    task automatic test_batch_accum();
        logic rdy, ep, seen;
        int nb;
        logic [VEC_W-1:0] d;
        start_run(1, 3, 1, 3, 0, rdy);
        send_chunk(32'd1);
        send_chunk(32'd2);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL s2_early_update busy=%b required=0", busy); end
        send_chunk(32'd3);
        wait_xupd(nb, ep, seen);
        total++;
        if ({seen, ep} !== 2'b11) begin bad++; $display("FAIL s2_xupd_epoch got=%b required=11", {seen, ep}); end
        total++;
        if (nb != 3) begin bad++; $display("FAIL s2_update_cycles got=%0d required=3", nb); end
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFFA}}) begin bad++; $display("FAIL s2_x got=%h required=all fffffffa", d); end
    endtask

    task automatic test_back_to_back();
        logic rdy, ep, seen;
        int nb;
        logic [VEC_W-1:0] d;
        start_run(1, 2, 1, 2, 0, rdy);
        drive_grad(32'd5, 1'b1);
        @(negedge clk);
        drive_grad(32'd7, 1'b1);
        @(negedge clk);
        drive_grad(32'd0, 1'b0);
        wait_xupd(nb, ep, seen);
        total++;
        if ({seen, ep, done} !== 3'b111) begin bad++; $display("FAIL s3_xupd_epoch_done got=%b required=111", {seen, ep, done}); end
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFF4}}) begin bad++; $display("FAIL s3_forward_x got=%h required=all fffffff4", d); end
    endtask

    task automatic test_multi_epoch();
        logic rdy, ep, seen;
        int nb;
        logic [VEC_W-1:0] d;
        start_run(2, 1, 1, 1, 1, rdy);
        send_chunk(32'd4);
        wait_xupd(nb, ep, seen);
        total++;
        if ({seen, ep, done} !== 3'b110) begin bad++; $display("FAIL me_first_epoch got=%b required=110", {seen, ep, done}); end
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFFE}}) begin bad++; $display("FAIL me_x1 got=%h required=all fffffffe", d); end
        send_chunk(32'hFFFF_FFF8);
        wait_xupd(nb, ep, seen);
        total++;
        if ({seen, ep, done} !== 3'b111) begin bad++; $display("FAIL me_second_epoch got=%b required=111", {seen, ep, done}); end
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'h0000_0002}}) begin bad++; $display("FAIL me_x2 got=%h required=all 00000002", d); end
    endtask

    task automatic test_overrun();
        logic rdy, ep, seen;
        int nb;
        logic [VEC_W-1:0] d;
        start_run(1, 2, 1, 1, 0, rdy);
        send_chunk(32'd3);
        drive_grad(32'd100, 1'b1);
        @(negedge clk);
        drive_grad(32'd0, 1'b0);
        wait_xupd(nb, ep, seen);
        total++;
        if ({seen, ep, err_overrun} !== 3'b101) begin bad++; $display("FAIL s4_drop got=%b required=101", {seen, ep, err_overrun}); end
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFFD}}) begin bad++; $display("FAIL s4_x_after_drop got=%h required=all fffffffd", d); end
        send_chunk(32'd2);
        wait_xupd(nb, ep, seen);
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFFB}}) begin bad++; $display("FAIL s4_x_final got=%h required=all fffffffb", d); end
    endtask

    task automatic test_saturate();
        logic rdy, ep, seen;
        int nb;
        logic [VEC_W-1:0] d;
        logic [31:0] exp_lane;
`ifdef SGD_UPDATE_SATURATE_EN
        exp_lane = 32'h8000_0000;
`else
        exp_lane = 32'h7FFF_FFFD;
`endif
        start_run(1, 2, 1, 1, 0, rdy);
        send_chunk(32'h7FFF_FFFF);
        wait_xupd(nb, ep, seen);
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'h8000_0001}}) begin bad++; $display("FAIL s5_x_setup got=%h required=all 80000001", d); end
        send_chunk(32'd4);
        wait_xupd(nb, ep, seen);
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{exp_lane}}) begin bad++; $display("FAIL s5_x_edge got=%h required=all %h", d, exp_lane); end
    endtask

    task automatic test_reset_mid_update();
        logic rdy;
        logic [VEC_W-1:0] d;
        start_run(1, 1, 2, 1, 0, rdy);
        send_chunk(32'd4);
        send_chunk(32'd4);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, x_updated, done, err_overrun} !== 4'b0) begin
            bad++;
            $display("FAIL s6_reset_mid_update got=%b required=0000", {busy, x_updated, done, err_overrun});
        end
        rst_n = 1'b1;
        read_x(0, d);
        total++;
        if (d !== {NUM_BITS_PER_BANK{32'hFFFF_FFFC}}) begin bad++; $display("FAIL s6_ram_kept got=%h required=all fffffffc", d); end
        read_x(1, d);
        total++;
        if (d !== '0) begin bad++; $display("FAIL s6_write_cancelled got=%h required=0", d); end
        start_run(1, 0, 2, 1, 0, rdy);
        total++;
        if ({rdy, done} !== 2'b11) begin bad++; $display("FAIL s6_zero_samples_done got=%b required=11", {rdy, done}); end
        read_x(0, d);
        total++;
        if (d !== '0) begin bad++; $display("FAIL s6_rezeroed got=%h required=0", d); end
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_batch_accum();
        test_back_to_back();
        test_multi_epoch();
        test_overrun();
        test_saturate();
        test_reset_mid_update();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
